// File: rtl/param_pipelined_core_if.sv
// rtl/param_pipelined_core_if.sv - instruction-fetch bus between core and instruction memory
//
// Ports (modports):
//   master (core)   : out imem_addr, in imem_data, in imem_valid
//   slave  (memory) : in imem_addr, out imem_data, out imem_valid
//   imem_addr  : fetch address, equal to the core's pc
//   imem_data  : instruction at imem_addr, returned in the same cycle
//   imem_valid : imem_data is usable this cycle; 0 stalls fetch
interface param_pipelined_core_if #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 8
);
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic               imem_valid;

  modport master (
    output imem_addr,
    input  imem_data,
    input  imem_valid
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    output imem_valid
  );
endinterface

// File: rtl/param_pipelined_core.sv
// rtl/param_pipelined_core.sv - parametrised 4-stage in-order core (ADD/SUB/MOV/J)
//
// Pipeline: IF -> IF/ID -> ID -> ID/EX -> EX -> EX/WB -> register file.
// Ports:
//   clk       : rising-edge clock
//   reset     : asynchronous active-low reset
//   imem      : fetch bus (master side), imem_addr = pc
//   pc        : current program counter
//   flush     : fetch slot discarded this cycle because a jump sits in ID
//   fwd_sel   : [0] EX rs operand taken from WB, [1] EX rd operand taken from WB
//   wb_en     : WB holds a valid register-writing instruction
//   wb_addr   : destination register in WB
//   wb_data   : result in WB
//   retired   : instructions leaving EX (jumps included), wrapping counter
//   dbg_addr  : debug register read address
//   dbg_data  : raw register file contents at dbg_addr (no bypass)
module param_pipelined_core #(
  parameter int DATA_W = 8,
  parameter int REG_AW = 3,
  parameter int PC_W   = 8,
  parameter int RET_W  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  param_pipelined_core_if.master imem,
  output logic [PC_W-1:0]        pc,
  output logic                   flush,
  output logic [1:0]             fwd_sel,
  output logic                   wb_en,
  output logic [REG_AW-1:0]      wb_addr,
  output logic [DATA_W-1:0]      wb_data,
  output logic [RET_W-1:0]       retired,
  input  logic [REG_AW-1:0]      dbg_addr,
  output logic [DATA_W-1:0]      dbg_data
);

  localparam int REG_CNT = 2**REG_AW;
  localparam int INSTR_W = 2 + 2*REG_AW;
  localparam int TGT_W   = 2*REG_AW;

  // Bits of the pc kept across a jump: everything above the jump target field.
  localparam logic [PC_W-1:0] PAGE_MASK = ~((PC_W'(1) << TGT_W) - PC_W'(1));

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MOV = 2'b10,
    OP_J   = 2'b11
  } op_t;

  // Register file
  logic [DATA_W-1:0] regs [REG_CNT];

  // IF/ID
  logic               if_id_valid;
  logic [INSTR_W-1:0] if_id_instr;
  logic [PC_W-1:0]    if_id_pc;

  // ID/EX
  logic               id_ex_valid;
  op_t                id_ex_op;
  logic [REG_AW-1:0]  id_ex_rd;
  logic [REG_AW-1:0]  id_ex_rs;
  logic [DATA_W-1:0]  id_ex_rd_val;
  logic [DATA_W-1:0]  id_ex_rs_val;

  // ID decode
  op_t               id_op;
  logic [REG_AW-1:0] id_rd;
  logic [REG_AW-1:0] id_rs;
  logic [TGT_W-1:0]  id_tgt;
  logic              id_jump;
  logic [PC_W-1:0]   jump_pc;
  logic [DATA_W-1:0] id_rd_val;
  logic [DATA_W-1:0] id_rs_val;

  // EX
  logic              fwd_rs;
  logic              fwd_rd;
  logic [DATA_W-1:0] ex_rs_val;
  logic [DATA_W-1:0] ex_rd_val;
  logic [DATA_W-1:0] ex_result;

  assign imem.imem_addr = pc;
  assign dbg_data       = regs[dbg_addr];

  assign id_op   = op_t'(if_id_instr[INSTR_W-1 -: 2]);
  assign id_rd   = if_id_instr[2*REG_AW-1 -: REG_AW];
  assign id_rs   = if_id_instr[REG_AW-1:0];
  assign id_tgt  = if_id_instr[TGT_W-1:0];
  assign id_jump = if_id_valid && (id_op == OP_J);
  assign flush   = id_jump;
  assign jump_pc = (if_id_pc & PAGE_MASK) | PC_W'(id_tgt);

  // The register file is written at the end of the WB cycle, so an ID read of
  // the same register in that cycle must take the value being written.
  assign id_rd_val = (wb_en && (wb_addr == id_rd)) ? wb_data : regs[id_rd];
  assign id_rs_val = (wb_en && (wb_addr == id_rs)) ? wb_data : regs[id_rs];

  // Back-to-back dependency: the producer is in WB while the consumer is in EX.
  assign fwd_rs    = id_ex_valid && wb_en && (wb_addr == id_ex_rs);
  assign fwd_rd    = id_ex_valid && wb_en && (wb_addr == id_ex_rd);
  assign fwd_sel   = {fwd_rd, fwd_rs};
  assign ex_rs_val = fwd_rs ? wb_data : id_ex_rs_val;
  assign ex_rd_val = fwd_rd ? wb_data : id_ex_rd_val;

  always_comb begin
    ex_result = ex_rd_val;
    case (id_ex_op)
      OP_ADD:  ex_result = ex_rd_val + ex_rs_val;
      OP_SUB:  ex_result = ex_rd_val - ex_rs_val;
      OP_MOV:  ex_result = ex_rs_val;
      default: ex_result = ex_rd_val;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc           <= '0;
      if_id_valid  <= 1'b0;
      if_id_instr  <= '0;
      if_id_pc     <= '0;
      id_ex_valid  <= 1'b0;
      id_ex_op     <= OP_ADD;
      id_ex_rd     <= '0;
      id_ex_rs     <= '0;
      id_ex_rd_val <= '0;
      id_ex_rs_val <= '0;
      wb_en        <= 1'b0;
      wb_addr      <= '0;
      wb_data      <= '0;
      retired      <= '0;
      for (int i = 0; i < REG_CNT; i++) begin
        regs[i] <= DATA_W'(i);
      end
    end else begin
      // Fetch: a jump in ID wins over whatever memory presents this cycle.
      if (id_jump) begin
        pc          <= jump_pc;
        if_id_valid <= 1'b0;
      end else if (imem.imem_valid) begin
        pc          <= pc + PC_W'(1);
        if_id_valid <= 1'b1;
        if_id_instr <= imem.imem_data;
        if_id_pc    <= pc;
      end else begin
        if_id_valid <= 1'b0;
      end

      // Decode -> execute
      id_ex_valid  <= if_id_valid;
      id_ex_op     <= id_op;
      id_ex_rd     <= id_rd;
      id_ex_rs     <= id_rs;
      id_ex_rd_val <= id_rd_val;
      id_ex_rs_val <= id_rs_val;

      // Execute -> write-back; a jump retires here but never writes.
      wb_en   <= id_ex_valid && (id_ex_op != OP_J);
      wb_addr <= id_ex_rd;
      wb_data <= ex_result;
      if (id_ex_valid) begin
        retired <= retired + RET_W'(1);
      end

      if (wb_en) begin
        regs[wb_addr] <= wb_data;
      end
    end
  end

endmodule

// File: tb/tb_param_pipelined_core.sv
// tb/tb_param_pipelined_core.sv - directed and random-program bench for param_pipelined_core
module tb_param_pipelined_core;
  localparam int DATA_W  = 8;
  localparam int REG_AW  = 3;
  localparam int PC_W    = 8;
  localparam int RET_W   = 16;
  localparam int INSTR_W = 2 + 2*REG_AW;
  localparam int REG_CNT = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [PC_W-1:0]   pc;
  logic              flush;
  logic [1:0]        fwd_sel;
  logic              wb_en;
  logic [REG_AW-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic [RET_W-1:0]  retired;
  logic [REG_AW-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_data;

  param_pipelined_core_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

  param_pipelined_core #(
    .DATA_W(DATA_W), .REG_AW(REG_AW), .PC_W(PC_W), .RET_W(RET_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .imem     (bus),
    .pc       (pc),
    .flush    (flush),
    .fwd_sel  (fwd_sel),
    .wb_en    (wb_en),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .retired  (retired),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Random-program reference: architectural (ISA-level) execution only.
  logic [INSTR_W-1:0] prog [256];
  logic [DATA_W-1:0]  mreg [REG_CNT];
  logic [PC_W-1:0]    mpc;
  int unsigned        consumed;
  int                 wb_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic [INSTR_W-1:0] d);
    bus.imem_valid = v;
    bus.imem_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset          = 1'b0;
    bus.imem_valid = 1'b0;
    bus.imem_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic check_reg(input string tag, input int addr, input logic [DATA_W-1:0] exp);
    dbg_addr = REG_AW'(addr);
    #1;
    check(tag, 32'(dbg_data), 32'(exp));
  endtask

  // Advances the ISA model to its next register-writing instruction.
  task automatic model_next(output logic [REG_AW-1:0] ea, output logic [DATA_W-1:0] ed,
                            output bit ok);
    logic [INSTR_W-1:0] ins;
    int guard;
    guard = 0;
    ok    = 1'b0;
    ea    = '0;
    ed    = '0;
    ins   = prog[mpc];
    while (ins[7:6] == 2'b11 && guard < 300) begin
      consumed++;
      mpc   = {mpc[7:6], ins[5:0]};
      ins   = prog[mpc];
      guard++;
    end
    if (ins[7:6] != 2'b11) begin
      ea = ins[5:3];
      case (ins[7:6])
        2'b00:   ed = DATA_W'(int'(mreg[ins[5:3]]) + int'(mreg[ins[2:0]]));
        2'b01:   ed = DATA_W'(int'(mreg[ins[5:3]]) - int'(mreg[ins[2:0]]) + 256);
        default: ed = mreg[ins[2:0]];
      endcase
      mreg[ea] = ed;
      consumed++;
      mpc = mpc + 8'd1;
      ok  = 1'b1;
    end
  endtask

  task automatic rand_cycle(input logic v);
    logic [REG_AW-1:0] ea;
    logic [DATA_W-1:0] ed;
    bit ok;
    step(v, prog[bus.imem_addr]);
    if (wb_en) begin
      wb_seen++;
      model_next(ea, ed, ok);
      if (!ok) begin
        check("rand_model_jump_loop", 32'(wb_en), 32'(1'b0));
      end else begin
        check("rand_wb_addr", 32'(wb_addr), 32'(ea));
        check("rand_wb_data", 32'(wb_data), 32'(ed));
        check("rand_retired", 32'(retired), 32'(consumed & 32'hFFFF));
      end
    end
  endtask

  initial begin
    dbg_addr       = '0;
    reset          = 1'b1;
    bus.imem_valid = 1'b0;
    bus.imem_data  = '0;

    // 1: reset state and a single ADD r1,r2
    do_reset();
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_wb_en", 32'(wb_en), 32'd0);
    check("rst_wb_addr", 32'(wb_addr), 32'd0);
    check("rst_wb_data", 32'(wb_data), 32'd0);
    check("rst_flush", 32'(flush), 32'd0);
    check("rst_fwd_sel", 32'(fwd_sel), 32'd0);
    check("rst_retired", 32'(retired), 32'd0);
    for (int i = 0; i < REG_CNT; i++) check_reg("rst_reg", i, DATA_W'(i));
    step(1'b1, 8'h0A);
    check("t1_pc_inc", 32'(pc), 32'd1);
    step(1'b0, 8'h00);
    check("t1_pc_hold", 32'(pc), 32'd1);
    step(1'b0, 8'h00);
    check("t1_wb_en", 32'(wb_en), 32'd1);
    check("t1_wb_addr", 32'(wb_addr), 32'd1);
    check("t1_wb_data", 32'(wb_data), 32'd3);
    step(1'b0, 8'h00);
    check("t1_wb_en_off", 32'(wb_en), 32'd0);
    check("t1_retired", 32'(retired), 32'd1);
    check_reg("t1_r1", 1, 8'd3);

    // 2: back-to-back dependency, rs forwarded
    do_reset();
    step(1'b1, 8'h0A);
    step(1'b1, 8'h19);
    step(1'b0, 8'h00);
    check("t2_fwd_sel", 32'(fwd_sel), 32'b01);
    step(1'b0, 8'h00);
    check("t2_wb_data", 32'(wb_data), 32'd6);
    step(1'b0, 8'h00);
    check_reg("t2_r3", 3, 8'd6);

    // 3a: one bubble apart, register-file bypass in ID
    do_reset();
    step(1'b1, 8'h0A);
    step(1'b0, 8'h00);
    step(1'b1, 8'h19);
    step(1'b0, 8'h00);
    check("t3a_fwd_sel", 32'(fwd_sel), 32'b00);
    step(1'b0, 8'h00);
    check("t3a_wb_data", 32'(wb_data), 32'd6);
    step(1'b0, 8'h00);
    check_reg("t3a_r3", 3, 8'd6);

    // 3b: ADD r1,r1 right after ADD r1,r2, both operands forwarded
    do_reset();
    step(1'b1, 8'h0A);
    step(1'b1, 8'h09);
    step(1'b0, 8'h00);
    check("t3b_fwd_sel", 32'(fwd_sel), 32'b11);
    step(1'b0, 8'h00);
    check("t3b_wb_data", 32'(wb_data), 32'd6);
    step(1'b0, 8'h00);
    check_reg("t3b_r1", 1, 8'd6);

    // 4: SUB wraps, MOV copies
    do_reset();
    step(1'b1, 8'h65);
    step(1'b1, 8'h9F);
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);
    check_reg("t4_r4", 4, 8'hFF);
    check_reg("t4_r3", 3, 8'd7);

    // 5: jump at pc=2 flushes the instruction fetched at pc=3
    do_reset();
    step(1'b1, 8'h0A);
    step(1'b1, 8'h19);
    check("t5_pc2", 32'(pc), 32'd2);
    step(1'b1, 8'hC5);
    check("t5_flush", 32'(flush), 32'd1);
    check("t5_pc3", 32'(pc), 32'd3);
    step(1'b1, 8'h12);
    check("t5_flush_off", 32'(flush), 32'd0);
    check("t5_pc_target", 32'(pc), 32'd5);
    step(1'b0, 8'h00);
    check("t5_j_no_wb", 32'(wb_en), 32'd0);
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);
    check("t5_retired", 32'(retired), 32'd3);
    check_reg("t5_r2_untouched", 2, 8'd2);
    check_reg("t5_r3", 3, 8'd6);

    // 6: reset with three instructions in flight
    do_reset();
    step(1'b1, 8'h0A);
    step(1'b1, 8'h19);
    step(1'b1, 8'h65);
    step(1'b1, 8'h12);
    check_reg("t6_r1_before", 1, 8'd3);
    reset = 1'b0;
    #1;
    check("t6_pc", 32'(pc), 32'd0);
    check("t6_wb_en", 32'(wb_en), 32'd0);
    check("t6_wb_data", 32'(wb_data), 32'd0);
    check("t6_retired", 32'(retired), 32'd0);
    check("t6_fwd_sel", 32'(fwd_sel), 32'd0);
    check_reg("t6_r1_after", 1, 8'd1);
    bus.imem_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 8'h00);
      check("t6_no_wb", 32'(wb_en), 32'd0);
    end

    // Random program with random fetch stalls against the ISA model
    for (int i = 0; i < 256; i++) begin
      logic [1:0] op;
      op = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      prog[i] = {op, 6'($urandom)};
    end
    for (int i = 0; i < REG_CNT; i++) mreg[i] = DATA_W'(i);
    mpc      = '0;
    consumed = 0;
    wb_seen  = 0;
    do_reset();
    for (int c = 0; c < 3000; c++) rand_cycle($urandom_range(0, 3) != 0);
    for (int c = 0; c < 5; c++) rand_cycle(1'b0);
    check("rand_enough_wb", 32'(wb_seen > 200), 32'd1);
    for (int i = 0; i < REG_CNT; i++) check_reg("rand_final_reg", i, mreg[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
